ssd1306_bus_arbiter: RTL and testbench

SSD1306_BUS_ARBITER -- requirements
Module: ssd1306_bus_arbiter

---
 rtl/ssd1306_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ssd1306_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_bus_arbiter.sv
`timescale 1ns/1ps
// ssd1306_bus_arbiter
//   Shares one SPI shift register (and the oled_dc pin) between two byte
//   requesters. Ownership is held across a multi-byte transaction until the
//   owner's byte marked "last" completes. A per-state watchdog forces release
//   when a transfer stalls.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in ARB_SEND/ARB_BUSY/ARB_HOLD (2..65535)
//
// Configuration macro
//   SSD1306_ARB_ROUND_ROBIN_EN  defined: simultaneous requests alternate
//                               (req0 favoured after reset);
//                               undefined: req0 always wins.
//
// Ports
//   clk_in, reset_n_in            clock (rising edge), async active-low reset
//   reqN_start/data/last/dc       byte request from requester N (N = 0,1)
//   reqN_ready                    ready as seen by requester N
//   sr_start/data/last/dc         to shared shift register / oled_dc
//   sr_ready                      shift register idle (1) / shifting (0)
//   grant                         one-hot owner, 00 = none
//   busy                          arbiter not idle
//   timeout_err                   one-cycle pulse on forced release
module ssd1306_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       req0_start,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  input  logic       req0_dc,
  output logic       req0_ready,
  input  logic       req1_start,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  input  logic       req1_dc,
  output logic       req1_ready,
  output logic       sr_start,
  output logic [7:0] sr_data,
  output logic       sr_last,
  output logic       sr_dc,
  input  logic       sr_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_BUSY, ARB_HOLD} arb_state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t  state, state_nxt;
  logic [1:0]  grant_r, grant_nxt;
  logic        last_r, last_nxt;
  logic        terr_r, terr_nxt;
  logic [15:0] cnt_r;
  logic [1:0]  win;

  logic       own_start, own_last, own_dc;
  logic [7:0] own_data;
  logic       active, timeout_hit;

  assign own_start = grant_r[1] ? req1_start : req0_start;
  assign own_data  = grant_r[1] ? req1_data  : req0_data;
  assign own_last  = grant_r[1] ? req1_last  : req0_last;
  assign own_dc    = grant_r[1] ? req1_dc    : req0_dc;

`ifdef SSD1306_ARB_ROUND_ROBIN_EN
  // ptr_r = 1 favours req0 on a tie; after each grant the other side is favoured.
  logic ptr_r;

  always_comb begin
    win = 2'b00;
    if (req0_start && req1_start) win = ptr_r ? 2'b01 : 2'b10;
    else if (req0_start)          win = 2'b01;
    else if (req1_start)          win = 2'b10;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)                                   ptr_r <= 1'b1;
    else if (state == ARB_IDLE && state_nxt == ARB_SEND) ptr_r <= win[1];
  end
`else
  always_comb begin
    win = 2'b00;
    if (req0_start)      win = 2'b01;
    else if (req1_start) win = 2'b10;
  end
`endif

  assign timeout_hit = (state != ARB_IDLE) && (cnt_r == CNT_LAST);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_r;
    last_nxt  = last_r;
    terr_nxt  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (sr_ready && (req0_start || req1_start)) begin
          grant_nxt = win;
          state_nxt = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (!sr_ready) begin
          last_nxt  = own_last;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (sr_ready) begin
          if (last_r) begin
            state_nxt = ARB_IDLE;
            grant_nxt = 2'b00;
          end else begin
            state_nxt = ARB_HOLD;
          end
        end
      end
      ARB_HOLD: begin
        if (own_start) state_nxt = ARB_SEND;
      end
      default: state_nxt = ARB_IDLE;
    endcase
    // Watchdog overrides whatever transition was chosen above.
    if (timeout_hit) begin
      state_nxt = ARB_IDLE;
      grant_nxt = 2'b00;
      last_nxt  = 1'b0;
      terr_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state   <= ARB_IDLE;
      grant_r <= '0;
      last_r  <= 1'b0;
      terr_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state   <= state_nxt;
      grant_r <= grant_nxt;
      last_r  <= last_nxt;
      terr_r  <= terr_nxt;
      if (state_nxt != state || state == ARB_IDLE) cnt_r <= '0;
      else                                         cnt_r <= cnt_r + 16'd1;
    end
  end

  assign active      = (state == ARB_SEND) || (state == ARB_BUSY);
  assign sr_start    = (state == ARB_SEND);
  assign sr_data     = active ? own_data : '0;
  assign sr_last     = active && own_last;
  assign sr_dc       = active && own_dc;
  assign grant       = grant_r;
  assign busy        = (state != ARB_IDLE);
  assign timeout_err = terr_r;

  // Non-owners see ready=1 so they park with start held; owner tracks sr_ready.
  always_comb begin
    req0_ready = 1'b1;
    req1_ready = 1'b1;
    case (state)
      ARB_IDLE: begin
        req0_ready = sr_ready;
        req1_ready = sr_ready;
      end
      ARB_SEND, ARB_BUSY: begin
        if (grant_r[0]) req0_ready = sr_ready;
        if (grant_r[1]) req1_ready = sr_ready;
      end
      default: begin
        req0_ready = 1'b1;
        req1_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ssd1306_bus_arbiter.sv
`timescale 1ns/1ps
module tb_ssd1306_bus_arbiter;

  logic       clk_in = 1'b0;
  logic       reset_n_in;
  logic       req0_start, req0_last, req0_dc, req0_ready;
  logic [7:0] req0_data;
  logic       req1_start, req1_last, req1_dc, req1_ready;
  logic [7:0] req1_data;
  logic       sr_start, sr_last, sr_dc, sr_ready;
  logic [7:0] sr_data;
  logic [1:0] grant;
  logic       busy, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  ssd1306_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .req0_start(req0_start), .req0_data(req0_data), .req0_last(req0_last),
    .req0_dc(req0_dc), .req0_ready(req0_ready),
    .req1_start(req1_start), .req1_data(req1_data), .req1_last(req1_last),
    .req1_dc(req1_dc), .req1_ready(req1_ready),
    .sr_start(sr_start), .sr_data(sr_data), .sr_last(sr_last), .sr_dc(sr_dc),
    .sr_ready(sr_ready), .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  logic [16:0] outs_w;
  assign outs_w = {grant, busy, sr_start, sr_data, sr_last, sr_dc,
                   req0_ready, req1_ready, timeout_err};

  function automatic logic [16:0] eo(input logic [1:0] g, input logic b, input logic s,
                                     input logic [7:0] d, input logic l, input logic dc,
                                     input logic r0, input logic r1, input logic te);
    return {g, b, s, d, l, dc, r0, r1, te};
  endfunction

  typedef struct {
    logic       r0s;
    logic [7:0] r0d;
    logic       r0l;
    logic       r0dc;
    logic       r1s;
    logic [7:0] r1d;
    logic       r1l;
    logic       r1dc;
    logic       srr;
    logic [16:0] exp;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0_start = 0; req0_data = 0; req0_last = 0; req0_dc = 0;
    req1_start = 0; req1_data = 0; req1_last = 0; req1_dc = 0;
    sr_ready = 1;
  endtask

  logic [7:0] bytes0 [3];
  logic       arb2_exp_g1;

  initial begin
    // req0 single byte 0xAE (command)
    vt[0]  = '{1'b1, 8'hAE, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, eo(2'b00,0,0,8'h00,0,0,1,1,0)};
    vt[1]  = '{1'b1, 8'hAE, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, eo(2'b01,1,1,8'hAE,1,0,1,1,0)};
    vt[2]  = '{1'b1, 8'hAE, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, eo(2'b01,1,1,8'hAE,1,0,0,1,0)};
    vt[3]  = '{1'b0, 8'hAE, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, eo(2'b01,1,0,8'hAE,1,0,0,1,0)};
    vt[4]  = '{1'b0, 8'hAE, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, eo(2'b01,1,0,8'hAE,1,0,1,1,0)};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, eo(2'b00,0,0,8'h00,0,0,1,1,0)};
    // req1 data byte 0x55 (dc=1)
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, eo(2'b00,0,0,8'h00,0,0,1,1,0)};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, eo(2'b10,1,1,8'h55,1,1,1,1,0)};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, eo(2'b10,1,1,8'h55,1,1,1,0,0)};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, eo(2'b10,1,0,8'h55,1,1,1,0,0)};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, eo(2'b10,1,0,8'h55,1,1,1,1,0)};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, eo(2'b00,0,0,8'h00,0,0,1,1,0)};
    // request while shift register still busy: no grant
    vt[12] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, eo(2'b00,0,0,8'h00,0,0,0,0,0)};
    vt[13] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, eo(2'b00,0,0,8'h00,0,0,0,0,0)};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, eo(2'b00,0,0,8'h00,0,0,1,1,0)};

    bytes0[0] = 8'h81; bytes0[1] = 8'h20; bytes0[2] = 8'h7F;
`ifdef SSD1306_ARB_ROUND_ROBIN_EN
    arb2_exp_g1 = 1'b1;
`else
    arb2_exp_g1 = 1'b0;
`endif

    clear_inputs();
    reset_n_in = 0;
    #3;
    chk("reset_state", outs_w, eo(2'b00,0,0,8'h00,0,0,1,1,0));
    @(negedge clk_in);
    reset_n_in = 1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      req0_start = vt[i].r0s; req0_data = vt[i].r0d; req0_last = vt[i].r0l; req0_dc = vt[i].r0dc;
      req1_start = vt[i].r1s; req1_data = vt[i].r1d; req1_last = vt[i].r1l; req1_dc = vt[i].r1dc;
      sr_ready = vt[i].srr;
      #1;
      chk($sformatf("vec%0d", i), outs_w, vt[i].exp);
    end

    // ---- req0 3-byte transaction while req1 waits ----
    @(negedge clk_in);
    clear_inputs();
    req0_start = 1; req0_data = bytes0[0]; req0_last = 0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk_in); #1;
      chk($sformatf("multi_send%0d_grant", b), grant, 2'b01);
      chk($sformatf("multi_send%0d_data", b), {sr_start, sr_data}, {1'b1, bytes0[b]});
      chk($sformatf("multi_send%0d_r1rdy", b), req1_ready, 1'b1);
      if (b == 0) begin
        req1_start = 1; req1_data = 8'h40; req1_last = 1; req1_dc = 1;
      end
      sr_ready = 0;
      @(negedge clk_in);
      req0_start = 0; sr_ready = 1; #1;
      chk($sformatf("multi_busy%0d", b), {grant, sr_start, req1_ready}, {2'b01, 1'b0, 1'b1});
      @(negedge clk_in); #1;
      if (b < 2) begin
        chk($sformatf("multi_hold%0d", b), outs_w, eo(2'b01,1,0,8'h00,0,0,1,1,0));
        req0_start = 1; req0_data = bytes0[b+1]; req0_last = (b == 1);
      end else begin
        chk("multi_release", {grant, req1_ready}, {2'b00, 1'b1});
      end
    end
    @(negedge clk_in); #1;
    chk("multi_req1_grant", {grant, sr_start, sr_data, sr_dc}, {2'b10, 1'b1, 8'h40, 1'b1});
    sr_ready = 0;
    @(negedge clk_in);
    req1_start = 0; sr_ready = 1;
    @(negedge clk_in); #1;
    chk("multi_req1_done", {grant, busy}, {2'b00, 1'b0});

    // ---- simultaneous requests, twice ----
    clear_inputs();
    @(negedge clk_in);
    req0_start = 1; req0_data = 8'hA1; req0_last = 1;
    req1_start = 1; req1_data = 8'hA2; req1_last = 1;
    @(negedge clk_in); #1;
    chk("arb1_grant", grant, 2'b01);
    sr_ready = 0;
    @(negedge clk_in);
    req0_start = 0; sr_ready = 1;
    @(negedge clk_in);
    req0_start = 1; #1;
    chk("arb1_release", grant, 2'b00);
    @(negedge clk_in); #1;
    chk("arb2_grant", grant, arb2_exp_g1 ? 2'b10 : 2'b01);
    sr_ready = 0;
    @(negedge clk_in);
    req0_start = 0; req1_start = 0; sr_ready = 1;
    @(negedge clk_in); #1;
    chk("arb2_release", {grant, busy}, {2'b00, 1'b0});

    // ---- watchdog with sr_ready stuck low ----
    clear_inputs();
    @(negedge clk_in);
    req0_start = 1; req0_data = 8'hC3; req0_last = 1;
    @(negedge clk_in);
    sr_ready = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in); #1;
      chk($sformatf("tmo_err_k%0d", k), timeout_err, (k == 8));
      chk($sformatf("tmo_own_k%0d", k), {grant, busy}, (k < 8) ? {2'b01, 1'b1} : {2'b00, 1'b0});
    end
    req0_start = 0; sr_ready = 1;

    // ---- reset during ARB_BUSY, then normal grant ----
    @(negedge clk_in);
    clear_inputs();
    req0_start = 1; req0_data = 8'h33; req0_last = 1;
    @(negedge clk_in);
    sr_ready = 0;
    @(negedge clk_in); #1;
    chk("rst_pre_busy", {grant, sr_start, sr_data}, {2'b01, 1'b0, 8'h33});
    #2 reset_n_in = 0;
    #1;
    chk("rst_async", {grant, busy, sr_start, sr_data, timeout_err}, {2'b00, 1'b0, 1'b0, 8'h00, 1'b0});
    req0_start = 0; sr_ready = 1;
    @(negedge clk_in);
    reset_n_in = 1;
    @(negedge clk_in);
    req1_start = 1; req1_data = 8'h22; req1_last = 1;
    @(negedge clk_in); #1;
    chk("rst_after_grant", {grant, sr_start, sr_data}, {2'b10, 1'b1, 8'h22});
    sr_ready = 0;
    @(negedge clk_in);
    req1_start = 0; sr_ready = 1;
    @(negedge clk_in); #1;
    chk("rst_after_done", {grant, busy}, {2'b00, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
